line_window_gen: RTL
====================

// Module: line_window_gen
// PURPOSE
//  Parametrised KSIZE x KSIZE sliding-window generator for the edge pipeline (Sobel/NMS/threshold stages).
//  Emits one window per image pixel, raster order, centred on that pixel; out-of-image taps forced to PAD_VALUE.
//  Valid/ready on both sides with full backpressure; drains the last R=KSIZE/2 rows itself.
// PARAMETERS
//  IMG_WIDTH   640  pixels per line (>= KSIZE)
//  IMG_HEIGHT  506  lines per frame (>= KSIZE)
//  KSIZE       3    window size; odd, 3..7
//  DATA_WIDTH  16   bits per pixel
//  PAD_VALUE   0    value substituted for taps outside the image
// PORTS
//  clk         in   1                      clock
//  rst         in   1                      synchronous, active-high reset
//  start       in   1                      pulse: arm for a new frame (ignored unless IDLE)
//  in_valid    in   1                      input pixel valid
//  in_ready    out  1                      block accepts input pixel
//  in_data     in   DATA_WIDTH             pixel, raster order
//  out_valid   out  1                      window valid
//  out_ready   in   1                      downstream accepts window
//  out_window  out  KSIZE*KSIZE*DATA_WIDTH tap(i,j) at [(i*KSIZE+j)*DATA_WIDTH +: DATA_WIDTH], i=0 top, j=0 left
//  out_row     out  clog2(IMG_HEIGHT)      centre row r
//  out_col     out  clog2(IMG_WIDTH)       centre col c
//  out_sof     out  1                      with out_valid: centre (0,0)
//  out_eof     out  1                      with out_valid: centre (H-1,W-1)
//  frame_done  out  1                      one-cycle pulse after last window accepted
// BEHAVIOUR
//  - Clock clk; reset rst, synchronous, active-high. On reset: state IDLE, all counters 0, line-buffer addr 0,
//    out_valid/in_ready/out_sof/out_eof/frame_done 0, out_window/out_row/out_col 0. RAM contents not cleared.
//  - R=KSIZE/2. Scan index p counts 0..H*W+R*W+R-1; a scan step occurs on in_valid&&in_ready (FILL/RUN)
//    or on an internal pad tick (FLUSH), and only when the output slot is free (!out_valid || out_ready).
//  - KSIZE-1 line buffers, IMG_WIDTH x DATA_WIDTH, single circular write address 0..W-1 (wraps at W-1);
//    KSIZE column shift registers per row tap give taps at linear index p-i*W-j.
//  - Window for centre q=p-(R*W+R): tap(i,j) = pixel(r+i-R, c+j-R), or PAD_VALUE if that row/col lies
//    outside [0,H-1]/[0,W-1]. Row wrap in column registers must be masked, never leaked.
//  - Latency: window for centre q is registered on the step that consumes scan index q+R*W+R;
//    out_valid rises the cycle after that step.
//  - FSM: IDLE -start-> FILL (p<R*W+R: accept, no output) -> RUN (accept and emit)
//    -p=H*W-> FLUSH (in_ready=0, feed PAD internally, emit) -> DONE (last window accepted:
//    frame_done=1 one cycle) -> IDLE.
//  - in_ready = (FILL|RUN) && (!out_valid || out_ready). Exactly H*W windows per frame, no duplicates, no gaps.
//  - out_valid held with stable out_window/out_row/out_col/flags until out_ready (no drop, no change while stalled).
//  - start outside IDLE ignored; in_valid in IDLE/FLUSH/DONE not accepted (in_ready=0).
//  - Simultaneous out_ready and new window: old accepted, new loaded same cycle (full throughput, 1 px/clk).
//  - rst mid-frame: abort immediately to IDLE; next frame after start is unaffected by stale RAM (masking).
// TESTING
//  - W=8,H=6,K=3, in_data=r*8+c, out_ready=1: 48 windows; centre (0,0) = {0,0,0,0,0,1,0,8,9} top-left first,
//    out_sof on first, out_eof on 48th, frame_done 1 cycle after.
//  - Same frame, centre (5,7): bottom row and right column PAD; tap(1,1)=47, tap(0,0)=38.
//  - out_ready toggled 1-in-3 random: window stream identical to unstalled run; in_ready=0 whenever slot full and not accepted.
//  - K=5, W=8,H=6: window (2,2) contains values 0..36 interior; (0,0) has 2 pad rows and 2 pad cols.
//  - rst asserted at pixel 20, then start and fresh frame of 0xFFFF: every non-pad tap 0xFFFF, count=48.
//  - start pulsed during RUN: ignored, frame count and window order unchanged.

Source files
------------

// File: rtl/line_window_if.sv
// Streaming bus for line_window_gen: pixel input, window output and frame control.
// Handshake: a transfer happens on a rising clk edge where valid && ready are both 1; once
// valid is raised its payload stays unchanged until that transfer, and ready may depend on valid.
interface line_window_if #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 506,
    parameter int KSIZE      = 3,
    parameter int DATA_WIDTH = 16
);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    logic                              start;
    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH-1:0]             in_data;
    logic                              out_valid;
    logic                              out_ready;
    logic [KSIZE*KSIZE*DATA_WIDTH-1:0] out_window;
    logic [ROW_W-1:0]                  out_row;
    logic [COL_W-1:0]                  out_col;
    logic                              out_sof;
    logic                              out_eof;
    logic                              frame_done;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_window, out_row, out_col, out_sof, out_eof, frame_done
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_window, out_row, out_col, out_sof, out_eof, frame_done
    );
endinterface

// File: rtl/line_window_gen.sv
// KSIZE x KSIZE sliding-window generator: line buffers plus column shift registers, one window
// per pixel in raster order, out-of-image taps replaced by PAD_VALUE, last R rows drained internally.
module line_window_gen #(
    parameter int                    IMG_WIDTH  = 640,
    parameter int                    IMG_HEIGHT = 506,
    parameter int                    KSIZE      = 3,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic         clk,
    input  logic         rst,
    line_window_if.slave bus,
    output logic [2:0]   dbg_state
);
    localparam int R     = KSIZE / 2;
    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int LEAD  = R * IMG_WIDTH + R;
    localparam int NSCAN = NPIX + LEAD;
    localparam int P_W   = $clog2(NSCAN + 1);
    localparam int A_W   = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    localparam logic [P_W-1:0]   P_LAST_FILL = P_W'(LEAD - 1);
    localparam logic [P_W-1:0]   P_LAST_RUN  = P_W'(NPIX - 1);
    localparam logic [P_W-1:0]   P_LAST_SCAN = P_W'(NSCAN - 1);
    localparam logic [A_W-1:0]   A_LAST      = A_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] C_LAST      = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] R_LAST      = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [P_W-1:0]   p;
    logic [A_W-1:0]   wa;
    logic [ROW_W-1:0] rc;
    logic [COL_W-1:0] cc;
    logic             last_stepped;

    logic [DATA_WIDTH-1:0] lb      [KSIZE-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] sr      [KSIZE][KSIZE-1];
    logic [DATA_WIDTH-1:0] rin     [KSIZE];
    logic [DATA_WIDTH-1:0] tap_lin [KSIZE][KSIZE];
    logic [KSIZE*KSIZE*DATA_WIDTH-1:0] win_next;

    logic accepting, slot_free, step, emit;

    assign accepting    = (state == S_FILL) || (state == S_RUN);
    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = accepting && slot_free;
    assign step         = slot_free && ((accepting && bus.in_valid) ||
                                        ((state == S_FLUSH) && !last_stepped));
    assign emit         = step && ((state == S_RUN) || (state == S_FLUSH));
    assign dbg_state    = state;

    // rin[i] is the pixel at linear index p - i*W; the draining phase feeds padding.
    always_comb begin
        rin[0] = (state == S_FLUSH) ? PAD_VALUE : bus.in_data;
        for (int i = 1; i < KSIZE; i++) begin
            rin[i] = lb[i-1][wa];
        end
    end

    always_comb begin
        for (int i = 0; i < KSIZE; i++) begin
            tap_lin[i][0] = rin[i];
            for (int j = 1; j < KSIZE; j++) begin
                tap_lin[i][j] = sr[i][j-1];
            end
        end
    end

    // Linear taps wrap across row ends and reach into stale lines; position masking hides both.
    always_comb begin
        int rr;
        int cq;
        win_next = '0;
        for (int iw = 0; iw < KSIZE; iw++) begin
            for (int jw = 0; jw < KSIZE; jw++) begin
                rr = int'(rc) + iw - R;
                cq = int'(cc) + jw - R;
                if (rr < 0 || rr >= IMG_HEIGHT || cq < 0 || cq >= IMG_WIDTH)
                    win_next[(iw*KSIZE+jw)*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
                else
                    win_next[(iw*KSIZE+jw)*DATA_WIDTH +: DATA_WIDTH] = tap_lin[KSIZE-1-iw][KSIZE-1-jw];
            end
        end
    end

    // Storage is never cleared: every stale value it could expose is masked above.
    always_ff @(posedge clk) begin
        if (step) begin
            for (int i = 0; i < KSIZE-1; i++) begin
                lb[i][wa] <= rin[i];
            end
            for (int i = 0; i < KSIZE; i++) begin
                sr[i][0] <= rin[i];
                for (int j = 1; j < KSIZE-1; j++) begin
                    sr[i][j] <= sr[i][j-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            p              <= '0;
            wa             <= '0;
            rc             <= '0;
            cc             <= '0;
            last_stepped   <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_window <= '0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.out_sof    <= 1'b0;
            bus.out_eof    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;

            if (step) begin
                p  <= p + 1'b1;
                wa <= (wa == A_LAST) ? '0 : wa + 1'b1;
            end

            if (emit) begin
                bus.out_valid  <= 1'b1;
                bus.out_window <= win_next;
                bus.out_row    <= rc;
                bus.out_col    <= cc;
                bus.out_sof    <= (rc == '0) && (cc == '0);
                bus.out_eof    <= (rc == R_LAST) && (cc == C_LAST);
                if (cc == C_LAST) begin
                    cc <= '0;
                    rc <= rc + 1'b1;
                end else begin
                    cc <= cc + 1'b1;
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
                bus.out_sof   <= 1'b0;
                bus.out_eof   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state        <= S_FILL;
                        p            <= '0;
                        wa           <= '0;
                        rc           <= '0;
                        cc           <= '0;
                        last_stepped <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (step && p == P_LAST_FILL) state <= S_RUN;
                end
                S_RUN: begin
                    if (step && p == P_LAST_RUN) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (step && p == P_LAST_SCAN) last_stepped <= 1'b1;
                    if (last_stepped && bus.out_valid && bus.out_ready) begin
                        state          <= S_DONE;
                        bus.frame_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
